// File: rtl/keccak_state_unloader.sv
// keccak_state_unloader: reads the 64 slices of the final Keccak state, transposes
// them into 25 lanes of 64 bits and hands the lanes out on a valid/ready port.
module keccak_state_unloader #(
    parameter int unsigned SLICEW = 25,
    parameter int unsigned LANEW  = 64,
    parameter int unsigned ADDRW  = 6,
    parameter int unsigned IDXW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              sliceRd,
    output logic [ADDRW-1:0]  sliceAddr,
    input  logic [SLICEW-1:0] sliceData,
    output logic              laneValid,
    input  logic              laneReady,
    output logic [LANEW-1:0]  laneData,
    output logic [IDXW-1:0]   laneIdx,
    output logic              busy,
    output logic              done
);

    // Read counter needs one extra bit so it can sit at LANEW once all reads are issued.
    localparam int unsigned CNTW = ADDRW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [IDXW-1:0]   lane_idx_q, lane_idx_d;
    logic              cap_vld_q;
    logic [ADDRW-1:0]  cap_addr_q;
    logic [LANEW-1:0]  buf_q [SLICEW];

    logic              rd_pending;
    logic              last_capture;
    logic              lane_hs;
    logic              last_lane;

    assign rd_pending   = (rd_cnt_q < CNTW'(LANEW));
    assign last_capture = cap_vld_q && (cap_addr_q == ADDRW'(LANEW - 1));
    assign lane_hs      = (state_q == S_DRAIN) && laneReady;
    assign last_lane    = (lane_idx_q == IDXW'(SLICEW - 1));
    assign laneIdx      = lane_idx_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fill until the last slice is captured, drain until lane 24 is taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)                state_d = S_FILL;
            S_FILL:  if (last_capture)         state_d = S_DRAIN;
            S_DRAIN: if (lane_hs && last_lane) state_d = S_DONE;
            S_DONE:                            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        sliceRd   = 1'b0;
        sliceAddr = '0;
        laneValid = 1'b0;
        laneData  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_FILL: begin
                busy      = 1'b1;
                sliceRd   = rd_pending;
                sliceAddr = rd_pending ? rd_cnt_q[ADDRW-1:0] : '0;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                laneValid = 1'b1;
                laneData  = buf_q[lane_idx_q];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Read counter and lane index next values.
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        lane_idx_d = lane_idx_q;
        if (state_q == S_IDLE && start) begin
            rd_cnt_d = '0;
        end else if (state_q == S_FILL && rd_pending) begin
            rd_cnt_d = rd_cnt_q + CNTW'(1);
        end
        if (state_q == S_FILL && last_capture) begin
            lane_idx_d = '0;
        end else if (lane_hs) begin
            lane_idx_d = last_lane ? '0 : lane_idx_q + IDXW'(1);
        end
    end

    // Counter registers and the delayed read strobe/address used to capture read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q   <= '0;
            lane_idx_q <= '0;
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            lane_idx_q <= lane_idx_d;
            cap_vld_q  <= sliceRd;
            cap_addr_q <= sliceAddr;
        end
    end

    // Transpose buffer: bit n of slice z lands in lane n, bit z.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < SLICEW; n++) begin
                buf_q[n] <= '0;
            end
        end else if (cap_vld_q) begin
            for (int n = 0; n < SLICEW; n++) begin
                buf_q[n][cap_addr_q] <= sliceData[n];
            end
        end
    end

endmodule

// File: tb/tb_keccak_state_unloader.sv
// Testbench for keccak_state_unloader: random and directed slice images checked against
// a transpose reference computed directly from the memory contents.
module tb_keccak_state_unloader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sliceRd;
    logic [5:0]  sliceAddr;
    logic [24:0] sliceData;
    logic        laneValid;
    logic        laneReady;
    logic [63:0] laneData;
    logic [4:0]  laneIdx;
    logic        busy;
    logic        done;

    logic [24:0] mem [64];
    logic [63:0] lane_ref [25];
    int errors = 0;
    int checks = 0;

    keccak_state_unloader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sliceRd   (sliceRd),
        .sliceAddr (sliceAddr),
        .sliceData (sliceData),
        .laneValid (laneValid),
        .laneReady (laneReady),
        .laneData  (laneData),
        .laneIdx   (laneIdx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Slice memory: data appears the cycle after the read; garbage otherwise.
    always @(posedge clk) begin
        if (sliceRd) sliceData <= mem[sliceAddr];
        else         sliceData <= 25'($urandom);
    end

    // Reference: lane n bit z is slice z bit n.
    task automatic build_ref();
        for (int n = 0; n < 25; n++)
            for (int z = 0; z < 64; z++)
                lane_ref[n][z] = mem[z][n];
    endtask

    task automatic fill_random();
        for (int z = 0; z < 64; z++) mem[z] = 25'($urandom);
        build_ref();
    endtask

    // Issue start and follow FILL: reads in cycles 1..64, first laneValid in cycle 66.
    task automatic start_unload(input bit poke);
        int c = 1;
        int first_valid = 0;
        int bad_rd = 0;
        int bad_addr = 0;
        bit exp_rd;
        start = 1'b1;
        @(negedge clk);
        start = poke ? 1'($urandom % 2) : 1'b0;
        while (c < 200) begin
            exp_rd = (c >= 1 && c <= 64);
            if (sliceRd !== exp_rd || busy !== 1'b1) bad_rd++;
            if (exp_rd && sliceAddr !== 6'(c - 1)) bad_addr++;
            if (!exp_rd && sliceAddr !== 6'd0) bad_addr++;
            if (laneValid === 1'b1) begin
                first_valid = c;
                break;
            end
            @(negedge clk);
            start = poke ? 1'($urandom % 2) : 1'b0;
            c++;
        end
        if (!poke) start = 1'b0;
        checks++;
        if (first_valid != 66) begin
            errors++;
            $display("FAIL first_valid: got cycle %0d, expected 66", first_valid);
        end
        checks++;
        if (bad_rd != 0) begin
            errors++;
            $display("FAIL read_strobe: %0d bad sliceRd/busy cycles, expected 0", bad_rd);
        end
        checks++;
        if (bad_addr != 0) begin
            errors++;
            $display("FAIL read_addr: %0d bad sliceAddr cycles, expected 0", bad_addr);
        end
    endtask

    // Drain all 25 lanes under a ready pattern, then check the done pulse.
    task automatic drain_and_check(input int mode, input bit poke);
        int idx = 0;
        int cyc = 0;
        bit r;
        while (idx < 25 && cyc < 400) begin
            checks++;
            if (laneValid !== 1'b1 || laneIdx !== 5'(idx) || laneData !== lane_ref[idx] ||
                busy !== 1'b1 || done !== 1'b0 || sliceRd !== 1'b0) begin
                errors++;
                $display("FAIL drain_lane cyc=%0d: valid=%b idx=%0d data=%h busy=%b done=%b, expected valid=1 idx=%0d data=%h busy=1 done=0",
                         cyc, laneValid, laneIdx, laneData, busy, done, idx, lane_ref[idx]);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom % 2);
            endcase
            laneReady = r;
            if (poke) start = 1'($urandom % 2);
            @(negedge clk);
            cyc++;
            if (r) idx++;
        end
        laneReady = 1'b0;
        start = 1'b0;
        checks++;
        if (idx != 25 || done !== 1'b1 || busy !== 1'b0 || laneValid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: lanes=%0d done=%b busy=%b valid=%b, expected lanes=25 done=1 busy=0 valid=0",
                     idx, done, busy, laneValid);
        end
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || laneValid !== 1'b0 || sliceRd !== 1'b0) begin
            errors++;
            $display("FAIL done_single: done=%b busy=%b valid=%b rd=%b, expected all 0",
                     done, busy, laneValid, sliceRd);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sliceRd !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b rd=%b, expected 0 0", busy, sliceRd);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        laneReady = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sliceRd, sliceAddr, laneValid, laneData, laneIdx, busy, done} !== 80'd0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b addr=%0d valid=%b data=%h idx=%0d busy=%b done=%b, expected all 0",
                     sliceRd, sliceAddr, laneValid, laneData, laneIdx, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({sliceRd, sliceAddr, laneValid, laneData, laneIdx, busy, done} !== 80'd0) begin
            errors++;
            $display("FAIL post_reset_outputs: rd=%b valid=%b busy=%b done=%b, expected all 0",
                     sliceRd, laneValid, busy, done);
        end
    endtask

    task automatic test_idle_ready();
        laneReady = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (laneValid !== 1'b0 || busy !== 1'b0 || laneIdx !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: valid=%b busy=%b idx=%0d done=%b, expected 0 0 0 0",
                     laneValid, busy, laneIdx, done);
        end
        laneReady = 1'b0;
    endtask

    task automatic test_pattern();
        for (int z = 0; z < 64; z++) mem[z] = 25'h1 << (z % 25);
        build_ref();
        start_unload(1'b0);
        checks++;
        if (laneData !== 64'h0004_0000_0200_0001) begin
            errors++;
            $display("FAIL pattern_lane0: got %h, expected 0004000002000001", laneData);
        end
        drain_and_check(0, 1'b0);
    endtask

    task automatic test_stall();
        fill_random();
        start_unload(1'b0);
        drain_and_check(1, 1'b0);
    endtask

    task automatic test_ones_zeros();
        for (int z = 0; z < 64; z++) mem[z] = 25'h1FFFFFF;
        build_ref();
        start_unload(1'b0);
        drain_and_check(0, 1'b0);
        for (int z = 0; z < 64; z++) mem[z] = 25'h0;
        build_ref();
        start_unload(1'b0);
        drain_and_check(2, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_random();
        start_unload(1'b0);
        for (int i = 0; i < 7; i++) begin
            laneReady = 1'b1;
            @(negedge clk);
        end
        laneReady = 1'b0;
        checks++;
        if (laneIdx !== 5'd7 || laneValid !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort_idx: idx=%0d valid=%b, expected 7 1", laneIdx, laneValid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({sliceRd, sliceAddr, laneValid, laneData, laneIdx, busy, done} !== 80'd0) begin
            errors++;
            $display("FAIL abort_outputs: valid=%b idx=%0d busy=%b data=%h, expected all 0",
                     laneValid, laneIdx, busy, laneData);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || laneValid !== 1'b0 || laneIdx !== 5'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b idx=%0d, expected 0 0 0", busy, laneValid, laneIdx);
        end
        fill_random();
        start_unload(1'b0);
        drain_and_check(0, 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_random();
        start_unload(1'b1);
        drain_and_check(2, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            fill_random();
            start_unload(1'b0);
            drain_and_check(2, 1'b0);
        end
    endtask

    initial begin
        sliceData = '0;
        test_reset();
        test_idle_ready();
        test_pattern();
        test_stall();
        test_ones_zeros();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
